// File: rtl/param_ctrl_pkg.sv
// Shared definitions for the front-panel parameter controller: FSM states, edit_sel indices,
// parameter limits/defaults and the saturating step helper.
package param_ctrl_pkg;

    typedef enum logic [1:0] {
        StView   = 2'd0,
        StEdit   = 2'd1,
        StCommit = 2'd2
    } state_e;

    localparam logic [1:0] SEL_SENS   = 2'd0;
    localparam logic [1:0] SEL_GAIN   = 2'd1;
    localparam logic [1:0] SEL_DECAY  = 2'd2;
    localparam logic [1:0] SEL_COLOUR = 2'd3;

    localparam logic [7:0] SENS_MIN    = 8'd0;
    localparam logic [7:0] SENS_MAX    = 8'd99;
    localparam logic [7:0] SENS_DEF    = 8'd50;
    localparam logic [7:0] GAIN_MIN    = 8'd0;
    localparam logic [7:0] GAIN_MAX    = 8'd15;
    localparam logic [7:0] GAIN_DEF    = 8'd8;
    localparam logic [7:0] DECAY_MIN   = 8'd1;
    localparam logic [7:0] DECAY_MAX   = 8'd31;
    localparam logic [7:0] DECAY_DEF   = 8'd4;
    localparam logic [7:0] COLOUR_MIN  = 8'd0;
    localparam logic [7:0] COLOUR_MAX  = 8'd7;
    localparam logic [7:0] COLOUR_DEF  = 8'd0;

    // Packed with index 0 = sensitivity, matching edit_sel.
    localparam logic [3:0][7:0] PARAM_DEFAULTS = {COLOUR_DEF, DECAY_DEF, GAIN_DEF, SENS_DEF};

    localparam int unsigned ACCEL_STEP = 4;

    function automatic logic [7:0] param_min(input logic [1:0] sel);
        case (sel)
            SEL_SENS:  return SENS_MIN;
            SEL_GAIN:  return GAIN_MIN;
            SEL_DECAY: return DECAY_MIN;
            default:   return COLOUR_MIN;
        endcase
    endfunction

    function automatic logic [7:0] param_max(input logic [1:0] sel);
        case (sel)
            SEL_SENS:  return SENS_MAX;
            SEL_GAIN:  return GAIN_MAX;
            SEL_DECAY: return DECAY_MAX;
            default:   return COLOUR_MAX;
        endcase
    endfunction

    // 9-bit step so a borrow below zero shows up in bit 8 rather than wrapping silently.
    function automatic logic [7:0] step_clamp(input logic [7:0] val, input logic up,
                                              input logic [2:0] step, input logic [7:0] lo,
                                              input logic [7:0] hi);
        logic [8:0] sum;
        sum = up ? ({1'b0, val} + {6'b0, step}) : ({1'b0, val} - {6'b0, step});
        if (sum[8]) begin
            return up ? hi : lo;
        end
        if (sum < {1'b0, lo}) begin
            return lo;
        end
        if (sum > {1'b0, hi}) begin
            return hi;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/step_accel.sv
// Encoder acceleration: repeated same-direction steps inside the window use ACCEL_STEP.
// Only instantiated when PARAM_ACCEL_EN is defined.
module step_accel #(
    parameter int unsigned ACCEL_WIN_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic       both_i,
    input  logic       up_i,
    output logic [2:0] step_o
);
    import param_ctrl_pkg::*;

    localparam logic [31:0] WIN = 32'(ACCEL_WIN_CYC);

    logic [31:0] cnt_q, cnt_d;
    logic        have_prev_q, have_prev_d;
    logic        last_up_q, last_up_d;

    assign step_o = (have_prev_q && (last_up_q == up_i) && (cnt_q < WIN)) ?
                    3'(ACCEL_STEP) : 3'd1;

    always_comb begin
        cnt_d       = cnt_q;
        have_prev_d = have_prev_q;
        last_up_d   = last_up_q;
        if (clear_i || both_i) begin
            // L+R together breaks the run so the next step starts slow.
            cnt_d       = '0;
            have_prev_d = 1'b0;
        end else if (step_i) begin
            cnt_d       = '0;
            have_prev_d = 1'b1;
            last_up_d   = up_i;
        end else if (cnt_q != WIN) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            have_prev_q <= 1'b0;
            last_up_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            have_prev_q <= have_prev_d;
            last_up_q   <= last_up_d;
        end
    end

endmodule

// File: rtl/param_controller.sv
// View/edit/commit controller for display mode and the four live spectrum parameters.
// Optional encoder acceleration is enabled by defining PARAM_ACCEL_EN.
module param_controller #(
    parameter int unsigned NUM_MODES     = 5,
    parameter int unsigned TIMEOUT_CYC   = 250_000_000,
    parameter int unsigned ACCEL_WIN_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       L_pulse,
    input  logic       R_pulse,
    input  logic       K_pulse,
    output logic [2:0] current_mode,
    output logic       edit_active,
    output logic [1:0] edit_sel,
    output logic [7:0] sensitivity,
    output logic [7:0] gain,
    output logic [7:0] decay,
    output logic [7:0] colour,
    output logic       param_update
);
    import param_ctrl_pkg::*;

    localparam logic [2:0]  MODE_MAX  = 3'(NUM_MODES - 1);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic            edit_active_q, edit_active_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0][7:0] live_q, live_d;
    logic [3:0][7:0] work_q, work_d;
    logic            upd_q, upd_d;
    logic [31:0]     idle_q, idle_d;

    logic       any_pulse, l_only, r_only, step_en;
    logic [2:0] step;

    assign any_pulse = L_pulse | R_pulse | K_pulse;
    assign l_only    = L_pulse & ~R_pulse & ~K_pulse;
    assign r_only    = R_pulse & ~L_pulse & ~K_pulse;
    assign step_en   = (state_q == StEdit) & (l_only | r_only);

`ifdef PARAM_ACCEL_EN
    step_accel #(
        .ACCEL_WIN_CYC(ACCEL_WIN_CYC)
    ) u_step_accel (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i((state_q != StEdit) | K_pulse),
        .step_i (step_en),
        .both_i (L_pulse & R_pulse),
        .up_i   (r_only),
        .step_o (step)
    );
`else
    logic unused_accel_win;
    assign unused_accel_win = ^ACCEL_WIN_CYC;
    assign step             = 3'd1;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        live_d  = live_q;
        work_d  = work_q;
        upd_d   = 1'b0;
        idle_d  = '0;
        unique case (state_q)
            StView: begin
                if (K_pulse) begin
                    state_d = StEdit;
                    sel_d   = SEL_SENS;
                    work_d  = live_q;
                end else if (l_only) begin
                    mode_d = (mode_q == 3'd0) ? MODE_MAX : mode_q - 3'd1;
                end else if (r_only) begin
                    mode_d = (mode_q == MODE_MAX) ? 3'd0 : mode_q + 3'd1;
                end
            end
            StEdit: begin
                idle_d = any_pulse ? '0 : idle_q + 32'd1;
                if (K_pulse) begin
                    if (sel_q == SEL_COLOUR) begin
                        state_d = StCommit;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else if (step_en) begin
                    work_d[sel_q] = step_clamp(work_q[sel_q], r_only, step,
                                               param_min(sel_q), param_max(sel_q));
                end else if (!any_pulse && idle_q == IDLE_LAST) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                live_d  = work_q;
                upd_d   = 1'b1;
                state_d = StView;
                sel_d   = SEL_SENS;
            end
            default: state_d = StView;
        endcase
        // Stays high through COMMIT, dropping together with the param_update strobe.
        edit_active_d = (state_d != StView);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StView;
            mode_q        <= 3'd0;
            edit_active_q <= 1'b0;
            sel_q         <= SEL_SENS;
            live_q        <= PARAM_DEFAULTS;
            work_q        <= PARAM_DEFAULTS;
            upd_q         <= 1'b0;
            idle_q        <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            edit_active_q <= edit_active_d;
            sel_q         <= sel_d;
            live_q        <= live_d;
            work_q        <= work_d;
            upd_q         <= upd_d;
            idle_q        <= idle_d;
        end
    end

    assign current_mode = mode_q;
    assign edit_active  = edit_active_q;
    assign edit_sel     = sel_q;
    assign sensitivity  = live_q[SEL_SENS];
    assign gain         = live_q[SEL_GAIN];
    assign decay        = live_q[SEL_DECAY];
    assign colour       = live_q[SEL_COLOUR];
    assign param_update = upd_q;

endmodule

// File: tb/tb_param_controller.sv
// Directed bench for param_controller: vector table for VIEW/EDIT sequencing plus
// hand-written commit, timeout, acceleration and async-reset sequences.
module tb_param_controller;

    localparam int unsigned TO  = 20;
    localparam int unsigned WIN = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       L_pulse = 1'b0, R_pulse = 1'b0, K_pulse = 1'b0;
    logic [2:0] current_mode;
    logic       edit_active;
    logic [1:0] edit_sel;
    logic [7:0] sensitivity, gain, decay, colour;
    logic       param_update;

    int checks = 0;
    int failures = 0;

    param_controller #(
        .NUM_MODES    (5),
        .TIMEOUT_CYC  (TO),
        .ACCEL_WIN_CYC(WIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .L_pulse     (L_pulse),
        .R_pulse     (R_pulse),
        .K_pulse     (K_pulse),
        .current_mode(current_mode),
        .edit_active (edit_active),
        .edit_sel    (edit_sel),
        .sensitivity (sensitivity),
        .gain        (gain),
        .decay       (decay),
        .colour      (colour),
        .param_update(param_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       l, r, k;
        logic [2:0] mode;
        logic       act;
        logic [1:0] sel;
        logic       upd;
        logic [7:0] sens, gain;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Call at a negedge; holds the inputs for one cycle and returns at the next negedge.
    task automatic drive(input logic l, input logic r, input logic k);
        L_pulse = l;
        R_pulse = r;
        K_pulse = k;
        @(negedge clk);
        L_pulse = 1'b0;
        R_pulse = 1'b0;
        K_pulse = 1'b0;
    endtask

    logic [7:0] exp_gain;
    int         n;
    logic       act_before;
    logic       seen;

    initial begin
        //         l  r  k  mode act sel upd sens gain
        vecs[0]  = '{0, 1, 0, 1, 0, 0, 0, 50, 8};
        vecs[1]  = '{0, 1, 0, 2, 0, 0, 0, 50, 8};
        vecs[2]  = '{0, 1, 0, 3, 0, 0, 0, 50, 8};
        vecs[3]  = '{0, 1, 0, 4, 0, 0, 0, 50, 8};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 0, 50, 8};
        vecs[5]  = '{0, 1, 0, 1, 0, 0, 0, 50, 8};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 50, 8};
        vecs[7]  = '{1, 0, 0, 4, 0, 0, 0, 50, 8};
        vecs[8]  = '{1, 1, 0, 4, 0, 0, 0, 50, 8};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 50, 8};
        vecs[10] = '{0, 0, 1, 0, 1, 0, 0, 50, 8};
        vecs[11] = '{0, 1, 1, 0, 1, 1, 0, 50, 8};
        vecs[12] = '{1, 1, 0, 0, 1, 1, 0, 50, 8};
        vecs[13] = '{0, 0, 1, 0, 1, 2, 0, 50, 8};
        vecs[14] = '{0, 0, 1, 0, 1, 3, 0, 50, 8};
        vecs[15] = '{0, 0, 1, 0, 1, 3, 0, 50, 8};
        vecs[16] = '{0, 1, 0, 0, 0, 0, 1, 50, 8};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 50, 8};
        vecs[18] = '{0, 1, 0, 1, 0, 0, 0, 50, 8};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {61'd0, current_mode}, 64'd0);
        check("reset_flags", {edit_active, edit_sel, param_update}, 4'b0);
        check("reset_live", {sensitivity, gain, decay, colour}, {8'd50, 8'd8, 8'd4, 8'd0});
        rst_n = 1'b1;
        @(negedge clk);

        // Table: mode wrap, ignored L+R, K-wins, edit_sel walk, commit strobe, COMMIT ignores R
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].l, vecs[i].r, vecs[i].k);
            check($sformatf("vec%0d", i),
                  {current_mode, edit_active, edit_sel, param_update, sensitivity, gain},
                  {vecs[i].mode, vecs[i].act, vecs[i].sel, vecs[i].upd, vecs[i].sens,
                   vecs[i].gain});
        end

        // Sensitivity saturates at 99; live value changes only with the strobe
        drive(0, 0, 1);
        for (int i = 0; i < 60; i++) drive(0, 1, 0);
        check("sens_hold_edit", {56'd0, sensitivity}, 64'd50);
        for (int i = 0; i < 3; i++) drive(0, 0, 1);
        check("sens_sel3", {edit_sel, sensitivity}, {2'd3, 8'd50});
        drive(0, 0, 1);
        check("sens_commit_cyc", {param_update, sensitivity}, {1'b0, 8'd50});
        drive(0, 0, 0);
        check("sens_update", {param_update, sensitivity, gain, decay, colour},
              {1'b1, 8'd99, 8'd8, 8'd4, 8'd0});

        // Decay clamps at its minimum of 1 and commits by timeout
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);
        check("decay_sel", {edit_active, edit_sel}, {1'b1, 2'd2});
        for (int i = 0; i < 10; i++) drive(1, 0, 0);
        n = 0;
        seen = 1'b0;
        act_before = 1'b0;
        for (int i = 1; i <= 4 * TO && !seen; i++) begin
            act_before = edit_active;
            @(negedge clk);
            if (param_update) begin
                seen = 1'b1;
                n = i;
            end
        end
        check("timeout_seen", {63'd0, seen}, 64'd1);
        check("timeout_cycles", 64'(n), 64'(TO + 1));
        check("timeout_decay", {edit_active, act_before, sensitivity, decay},
              {1'b0, 1'b1, 8'd99, 8'd1});

        // Gain step sequence, pulses 10 cycles apart
`ifdef PARAM_ACCEL_EN
        exp_gain = 8'd15;
`else
        exp_gain = 8'd11;
`endif
        drive(0, 0, 1);
        drive(0, 0, 1);
        for (int p = 0; p < 3; p++) begin
            drive(0, 1, 0);
            if (p < 2) for (int j = 0; j < 9; j++) drive(0, 0, 0);
        end
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 0);
        check("gain_steps", {param_update, gain, decay}, {1'b1, exp_gain, 8'd1});

        // Async reset mid-edit discards work and clears outputs immediately
        drive(0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async", {current_mode, edit_active, edit_sel, param_update, sensitivity, gain,
                            decay},
              {3'd0, 1'b0, 2'd0, 1'b0, 8'd50, 8'd8, 8'd4});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0);
            if (param_update) seen = 1'b1;
        end
        check("rst_no_update", {seen, sensitivity}, {1'b0, 8'd50});
        drive(0, 1, 0);
        check("rst_view", {current_mode, edit_active}, {3'd1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
